// File: rtl/feeder_pkg.sv
// Shared constants and types for the systolic row feeder and its skew pipeline.
package feeder_pkg;

  localparam int FPW_DEF = 32;
  localparam logic [FPW_DEF-1:0] FP32_POS_ZERO = 32'h0000_0000;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_t;

endpackage

// File: rtl/skew_delay.sv
// Fixed-latency shift register (valid+data) with async clear; lags one array row DLY cycles behind row 0.
module skew_delay #(
  parameter int W   = 33,
  parameter int DLY = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out
);

  logic [W-1:0] sr_q [DLY];
  logic [W-1:0] sr_d [DLY];

  always_comb begin
    sr_d[0] = d_in;
    for (int i = 1; i < DLY; i++) sr_d[i] = sr_q[i-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DLY; i++) sr_q[i] <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign d_out = sr_q[DLY-1];

endmodule

// File: rtl/systolic_row_feeder.sv
// Left-edge operand feeder: buffers a tile of vectors, then replays it with row r lagging row 0 by r cycles.
// FEED_PINGPONG_EN adds a second buffer bank so the next tile fills while the current one issues.
//   state    | meaning
//   ST_FILL  | idle, accepting vectors into the fill bank
//   ST_ISSUE | replaying a tile onto the array (busy)
module systolic_row_feeder
  import feeder_pkg::*;
#(
  parameter int FPW       = FPW_DEF,
  parameter int ROWS      = 4,
  parameter int K_MAX     = 16,
  parameter int ISSUE_GAP = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [ROWS*FPW-1:0]  s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [ROWS*FPW-1:0]  m_d,
  output logic [ROWS-1:0]      m_v,
  output logic                 busy,
  output logic                 done,
  output logic                 err_ovf
);

`ifdef FEED_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  localparam int NB = PP ? 2 : 1;
  localparam int AW = $clog2(NB*K_MAX);
  localparam int CW = $clog2(K_MAX+1);
  localparam int GW = $clog2(ISSUE_GAP+1);
  localparam logic [ROWS*FPW-1:0] ZERO_VEC = {ROWS{FPW'(FP32_POS_ZERO)}};

  state_t              state_q, state_d;
  bank_t               fill_bank_q, fill_bank_d, iss_bank_q, iss_bank_d, nxt_bank;
  logic                pend_q, pend_d;
  logic [CW-1:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, out_cnt_q, out_cnt_d;
  logic [CW-1:0]       len_q [2];
  logic [CW-1:0]       len_d [2];
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                err_ovf_q, err_ovf_d;
  logic                s0_v_q, s0_v_d;
  logic [ROWS*FPW-1:0] s0_d_q, s0_d_d;
  logic [ROWS*FPW-1:0] buf_mem [NB*K_MAX];
  logic                hs, last_hs, done_w;

  function automatic logic [AW-1:0] buf_idx(input bank_t b, input logic [CW-1:0] k);
    return AW'(int'(b) * K_MAX + int'(k));
  endfunction

  assign s_ready = rstn && ((state_q == ST_FILL) || (PP && !pend_q));
  assign hs      = s_valid && s_ready;
  // Reaching the last buffer slot closes the tile even without s_last.
  assign last_hs = hs && (s_last || (wr_cnt_q == CW'(K_MAX-1)));
  assign done_w  = (state_q == ST_ISSUE) && m_v[ROWS-1] &&
                   (out_cnt_q == len_q[iss_bank_q] - CW'(1));

  always_comb begin
    state_d     = state_q;
    fill_bank_d = fill_bank_q;
    iss_bank_d  = iss_bank_q;
    pend_d      = pend_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_cnt_d   = out_cnt_q;
    len_d       = len_q;
    gap_cnt_d   = gap_cnt_q;
    err_ovf_d   = err_ovf_q;
    s0_v_d      = 1'b0;
    s0_d_d      = ZERO_VEC;
    nxt_bank    = bank_t'(~iss_bank_q);

    if (state_q == ST_ISSUE) begin
      if (m_v[ROWS-1] && !done_w) out_cnt_d = out_cnt_q + CW'(1);
      if (done_w) begin
        if (pend_q) begin
          // Back-to-back: first vector of the pending bank leaves on the edge that ends the current tile.
          iss_bank_d = nxt_bank;
          pend_d     = 1'b0;
          s0_v_d     = 1'b1;
          s0_d_d     = buf_mem[buf_idx(nxt_bank, '0)];
          rd_cnt_d   = CW'(1);
          gap_cnt_d  = GW'(ISSUE_GAP-1);
          out_cnt_d  = '0;
        end else begin
          state_d = ST_FILL;
        end
      end else if (gap_cnt_q != '0) begin
        gap_cnt_d = gap_cnt_q - GW'(1);
      end else if (rd_cnt_q < len_q[iss_bank_q]) begin
        s0_v_d    = 1'b1;
        s0_d_d    = buf_mem[buf_idx(iss_bank_q, rd_cnt_q)];
        rd_cnt_d  = rd_cnt_q + CW'(1);
        gap_cnt_d = GW'(ISSUE_GAP-1);
      end
    end

    if (hs) begin
      wr_cnt_d = wr_cnt_q + CW'(1);
      if (last_hs) begin
        wr_cnt_d           = '0;
        len_d[fill_bank_q] = wr_cnt_q + CW'(1);
        if (!s_last) err_ovf_d = 1'b1;
        if (PP) fill_bank_d = bank_t'(~fill_bank_q);
        if ((state_q == ST_FILL) || (done_w && !pend_q)) begin
          state_d    = ST_ISSUE;
          iss_bank_d = fill_bank_q;
          rd_cnt_d   = '0;
          gap_cnt_d  = '0;
          out_cnt_d  = '0;
        end else begin
          pend_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_FILL;
      fill_bank_q <= BANK_A;
      iss_bank_q  <= BANK_A;
      pend_q      <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      gap_cnt_q   <= '0;
      err_ovf_q   <= 1'b0;
      s0_v_q      <= 1'b0;
      s0_d_q      <= '0;
    end else begin
      state_q     <= state_d;
      fill_bank_q <= fill_bank_d;
      iss_bank_q  <= iss_bank_d;
      pend_q      <= pend_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      len_q       <= len_d;
      gap_cnt_q   <= gap_cnt_d;
      err_ovf_q   <= err_ovf_d;
      s0_v_q      <= s0_v_d;
      s0_d_q      <= s0_d_d;
    end
  end

  // Tile storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (hs) buf_mem[buf_idx(fill_bank_q, wr_cnt_q)] <= s_data;
  end

  assign m_v[0]       = s0_v_q;
  assign m_d[FPW-1:0] = s0_d_q[FPW-1:0];

  for (genvar r = 1; r < ROWS; r++) begin : g_skew
    logic [FPW:0] row_out;
    skew_delay #(.W(FPW+1), .DLY(r)) u_skew (
      .clk   (clk),
      .rstn  (rstn),
      .d_in  ({s0_v_q, s0_d_q[r*FPW +: FPW]}),
      .d_out (row_out)
    );
    assign m_v[r]           = row_out[FPW];
    assign m_d[r*FPW +: FPW] = row_out[FPW-1:0];
  end

  assign busy    = (state_q == ST_ISSUE);
  assign done    = done_w;
  assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Directed bench for systolic_row_feeder: one instance at issue gap 1, one at issue gap 4.
module tb_systolic_row_feeder;

  localparam int FPW   = 32;
  localparam int ROWS  = 4;
  localparam int K_MAX = 16;
  localparam int DW    = ROWS*FPW;
`ifdef FEED_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_valid_a = 1'b0, s_valid_b = 1'b0;
  logic          s_ready_a, s_ready_b, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [DW-1:0] m_d_a, m_d_b;
  logic [ROWS-1:0] m_v_a, m_v_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_vec [K_MAX];

  always #5 clk = ~clk;

  systolic_row_feeder #(.FPW(FPW), .ROWS(ROWS), .K_MAX(K_MAX), .ISSUE_GAP(1)) u_dut_a (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid_a), .s_last(s_last),
    .s_ready(s_ready_a), .m_d(m_d_a), .m_v(m_v_a), .busy(busy_a), .done(done_a), .err_ovf(ovf_a));

  systolic_row_feeder #(.FPW(FPW), .ROWS(ROWS), .K_MAX(K_MAX), .ISSUE_GAP(4)) u_dut_b (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid_b), .s_last(s_last),
    .s_ready(s_ready_b), .m_d(m_d_b), .m_v(m_v_b), .busy(busy_b), .done(done_b), .err_ovf(ovf_b));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit sel, output logic [ROWS-1:0] mv, output logic [DW-1:0] md,
                        output logic dn, output logic bs, output logic rdy, output logic ovf);
    mv  = sel ? m_v_b : m_v_a;
    md  = sel ? m_d_b : m_d_a;
    dn  = sel ? done_b : done_a;
    bs  = sel ? busy_b : busy_a;
    rdy = sel ? s_ready_b : s_ready_a;
    ovf = sel ? ovf_b : ovf_a;
  endtask

  // mode 0: every row carries 1.0/2.0/3.0; mode 1: distinct value per (vector,row)
  task automatic set_pattern(input int mode, input int base);
    logic [31:0] fl [3];
    fl[0] = 32'h3F80_0000; fl[1] = 32'h4000_0000; fl[2] = 32'h4040_0000;
    for (int k = 0; k < K_MAX; k++)
      for (int r = 0; r < ROWS; r++)
        exp_vec[k][r*FPW +: FPW] = (mode == 0 && k < 3) ? fl[k]
                                   : 32'h4100_0000 + 32'((base + k) * 256 + r);
  endtask

  task automatic send(input bit sel, input int n, input bit toggle, input bit use_last);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      s_data = exp_vec[k];
      s_last = use_last && (k == n-1);
      if (sel) s_valid_b = 1'b1; else s_valid_a = 1'b1;
      @(posedge clk); #1;
      if (toggle && k < n-1) begin
        @(negedge clk);
        s_data = {ROWS{32'hDEAD_BEEF}};
        s_last = 1'b1;
        s_valid_a = 1'b0; s_valid_b = 1'b0;
      end
    end
    s_valid_a = 1'b0; s_valid_b = 1'b0; s_last = 1'b0;
  endtask

  // Called #1 after the edge that accepted the final vector.
  task automatic expect_issue(input bit sel, input int len, input int gap);
    logic [ROWS-1:0] mv, ev;
    logic [DW-1:0]   md, ed;
    logic dn, bs, rdy, ovf;
    int tend;
    tend = (len-1)*gap + ROWS;
    sample(sel, mv, md, dn, bs, rdy, ovf);
    check("e0_busy", 128'(bs), 128'(1));
    check("e0_ready", 128'(rdy), 128'(PP));
    check("e0_mv", 128'(mv), 128'(0));
    for (int t = 1; t <= tend; t++) begin
      @(posedge clk); #1;
      sample(sel, mv, md, dn, bs, rdy, ovf);
      ev = '0; ed = '0;
      for (int r = 0; r < ROWS; r++) begin
        int j;
        j = t - 1 - r;
        if (j >= 0 && (j % gap) == 0 && (j / gap) < len) begin
          ev[r] = 1'b1;
          ed[r*FPW +: FPW] = exp_vec[j/gap][r*FPW +: FPW];
        end
      end
      check($sformatf("mv t=%0d", t), 128'(mv), 128'(ev));
      check($sformatf("md t=%0d", t), 128'(md), 128'(ed));
      check($sformatf("done t=%0d", t), 128'(dn), 128'(t == tend));
      check($sformatf("busy t=%0d", t), 128'(bs), 128'(1));
    end
    @(posedge clk); #1;
    sample(sel, mv, md, dn, bs, rdy, ovf);
    check("end_busy", 128'(bs), 128'(0));
    check("end_ready", 128'(rdy), 128'(1));
    check("end_mv", 128'(mv), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROWS-1:0] mv;
    logic [DW-1:0]   md;
    logic dn, bs, rdy, ovf;

    #1;
    sample(0, mv, md, dn, bs, rdy, ovf);
    check("rst_ready", 128'(rdy), 128'(0));
    check("rst_mv", 128'(mv), 128'(0));
    check("rst_md", 128'(md), 128'(0));
    check("rst_busy", 128'(bs), 128'(0));
    check("rst_done", 128'(dn), 128'(0));
    check("rst_ovf", 128'(ovf), 128'(0));
    check("rst_ready_b", 128'(s_ready_b), 128'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rel_ready", 128'(s_ready_a), 128'(1));

    // 1: three vectors, gap 1
    set_pattern(0, 0);
    send(0, 3, 1'b0, 1'b1);
    expect_issue(0, 3, 1);

    // 2: gap 4, two vectors
    set_pattern(1, 0);
    send(1, 2, 1'b0, 1'b1);
    expect_issue(1, 2, 4);

    // 3: valid toggled, junk on idle cycles
    set_pattern(1, 8);
    send(0, 3, 1'b1, 1'b1);
    expect_issue(0, 3, 1);
    check("t3_ovf", 128'(ovf_a), 128'(0));

    // 4: overflow at K_MAX, sticky into the next tile
    set_pattern(1, 20);
    send(0, K_MAX, 1'b0, 1'b0);
    check("t4_ovf_set", 128'(ovf_a), 128'(1));
    expect_issue(0, K_MAX, 1);
    set_pattern(1, 40);
    send(0, 1, 1'b0, 1'b1);
    check("t4_ovf_hold", 128'(ovf_a), 128'(1));
    expect_issue(0, 1, 1);

    // 5: reset mid-issue
    set_pattern(1, 60);
    send(0, 3, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_pre_mv", 128'(m_v_a), 128'(4'b0111));
    rstn = 1'b0;
    #1;
    check("t5_mv", 128'(m_v_a), 128'(0));
    check("t5_md", 128'(m_d_a), 128'(0));
    check("t5_done", 128'(done_a), 128'(0));
    check("t5_busy", 128'(busy_a), 128'(0));
    check("t5_ready", 128'(s_ready_a), 128'(0));
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("t5_rel_ready", 128'(s_ready_a), 128'(1));
    check("t5_ovf_clr", 128'(ovf_a), 128'(0));
    set_pattern(1, 80);
    send(0, 1, 1'b0, 1'b1);
    expect_issue(0, 1, 1);

`ifdef FEED_PINGPONG_EN
    // 6: tile B filled while tile A issues
    begin
      logic [DW-1:0] bvec [2];
      set_pattern(1, 100);
      bvec[0] = {ROWS{32'h4200_0001}};
      bvec[1] = {ROWS{32'h4200_0002}};
      send(0, 3, 1'b0, 1'b1);
      @(negedge clk); s_data = bvec[0]; s_last = 1'b0; s_valid_a = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); s_data = bvec[1]; s_last = 1'b1;
      @(posedge clk); #1;
      s_valid_a = 1'b0; s_last = 1'b0;
      for (int t = 3; t <= 12; t++) begin
        if (t > 3) begin @(posedge clk); #1; end
        check($sformatf("pp done t=%0d", t), 128'(done_a), 128'(t == 6 || t == 11));
        check($sformatf("pp busy t=%0d", t), 128'(busy_a), 128'(t <= 11));
        check($sformatf("pp ready t=%0d", t), 128'(s_ready_a), 128'(t >= 7));
        check($sformatf("pp v0 t=%0d", t), 128'(m_v_a[0]), 128'(t == 3 || t == 7 || t == 8));
        if (t == 7) check("pp d0 b0", 128'(m_d_a[FPW-1:0]), 128'(bvec[0][FPW-1:0]));
        if (t == 8) check("pp d0 b1", 128'(m_d_a[FPW-1:0]), 128'(bvec[1][FPW-1:0]));
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
